// File: rtl/yags_direction_cache_if.sv
// Fetch/EX-side bundle for one YAGS exception cache: lookup request/response,
// resolved-branch update, and flush control/status.
interface yags_direction_cache_if #(
  parameter int PC_size    = 10,
  parameter int GHR_size   = 10,
  parameter int Index_bits = 4,
  parameter int Ways       = 2
) ();
  localparam int WAY_W = (Ways > 1) ? $clog2(Ways) : 1;

  // No backpressure anywhere: a request is taken on any edge where its
  // valid is high, and resp_valid is a one-cycle strobe for the lookup
  // sampled on the previous edge.
  logic                  lookup_valid;
  logic [PC_size-1:0]    lookup_pc;
  logic [GHR_size-1:0]   lookup_ghr;
  logic                  resp_valid;
  logic                  resp_hit;
  logic                  resp_pred;
  logic [Index_bits-1:0] resp_index;
  logic [WAY_W-1:0]      resp_way;
  logic                  update_valid;
  logic [PC_size-1:0]    update_pc;
  logic [Index_bits-1:0] update_index;
  logic [WAY_W-1:0]      update_way;
  logic                  update_hit;
  logic                  update_pht_pred;
  logic                  update_taken;
  logic                  flush_req;
  logic                  flush_busy;
  logic                  flush_state_dbg;

  modport master (
    output lookup_valid, lookup_pc, lookup_ghr,
    input  resp_valid, resp_hit, resp_pred, resp_index, resp_way,
    output update_valid, update_pc, update_index, update_way, update_hit,
    output update_pht_pred, update_taken, flush_req,
    input  flush_busy, flush_state_dbg
  );

  modport slave (
    input  lookup_valid, lookup_pc, lookup_ghr,
    output resp_valid, resp_hit, resp_pred, resp_index, resp_way,
    input  update_valid, update_pc, update_index, update_way, update_hit,
    input  update_pht_pred, update_taken, flush_req,
    output flush_busy, flush_state_dbg
  );
endinterface

// File: rtl/yags_direction_cache.sv
// YAGS exception cache: set-associative tagged counters with registered lookup,
// EX-driven update/allocate, round-robin victims and a set-by-set flush walker.
module yags_direction_cache #(
  parameter int PC_size    = 10,
  parameter int GHR_size   = 10,
  parameter int Index_bits = 4,
  parameter int Ways       = 2,
  parameter int Tag_size   = 8,
  parameter int Ctr_bits   = 2,
  parameter int MODE       = 0
) (
  input logic clk,
  input logic rst,
  yags_direction_cache_if.slave bus
);
  localparam int SETS  = 1 << Index_bits;
  localparam int WAY_W = (Ways > 1) ? $clog2(Ways) : 1;
  localparam logic [Ctr_bits-1:0] CTR_MAX     = '1;
  localparam logic [Ctr_bits-1:0] CTR_WEAK_T  = Ctr_bits'(1 << (Ctr_bits - 1));
  localparam logic [Ctr_bits-1:0] CTR_WEAK_NT = Ctr_bits'((1 << (Ctr_bits - 1)) - 1);

  typedef enum logic {IDLE = 1'b0, WALK = 1'b1} flush_state_t;

  flush_state_t          state_q, state_d;
  logic [Index_bits-1:0] walk_ptr_q, walk_ptr_d;

  logic                ent_valid [SETS][Ways];
  logic [Tag_size-1:0] ent_tag   [SETS][Ways];
  logic [Ctr_bits-1:0] ent_ctr   [SETS][Ways];
  logic [WAY_W-1:0]    rr_q      [SETS];

  logic                  resp_valid_q, resp_hit_q, resp_pred_q;
  logic [Index_bits-1:0] resp_index_q;
  logic [WAY_W-1:0]      resp_way_q;

  logic                  walking;
  logic [Index_bits-1:0] lk_set;
  logic [Tag_size-1:0]   lk_tag;
  logic                  lk_hit;
  logic [WAY_W-1:0]      lk_way;
  logic                  upd_en, upd_exception, victim_found;
  logic [WAY_W-1:0]      victim_way;
  logic [Ctr_bits-1:0]   upd_ctr_cur, upd_ctr_next;
  logic                  unused_bits;

  assign walking     = (state_q == WALK);
  assign lk_set      = bus.lookup_pc[Index_bits-1:0] ^ bus.lookup_ghr[Index_bits-1:0];
  assign lk_tag      = bus.lookup_pc[Tag_size-1:0];
  assign unused_bits = ^{bus.lookup_pc, bus.lookup_ghr, bus.update_pc};

  // Flush walker: rst forces a fresh walk from set 0; requests mid-walk are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WALK;
      walk_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      walk_ptr_q <= walk_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    walk_ptr_d = walk_ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d    = WALK;
          walk_ptr_d = '0;
        end
      end
      WALK: begin
        walk_ptr_d = walk_ptr_q + 1'b1;
        if (walk_ptr_q == Index_bits'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Descending scan so the lowest matching way wins.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = Ways - 1; w >= 0; w--) begin
      if (ent_valid[lk_set][w] && ent_tag[lk_set][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_pred_q  <= 1'b0;
      resp_index_q <= '0;
      resp_way_q   <= '0;
    end else begin
      resp_valid_q <= bus.lookup_valid;
      if (bus.lookup_valid) begin
        resp_index_q <= lk_set;
        resp_hit_q   <= lk_hit && !walking;
        resp_pred_q  <= lk_hit && !walking && ent_ctr[lk_set][lk_way][Ctr_bits-1];
        resp_way_q   <= (lk_hit && !walking) ? lk_way : '0;
      end else begin
        resp_hit_q  <= 1'b0;
        resp_pred_q <= 1'b0;
        resp_way_q  <= '0;
      end
    end
  end

  always_comb begin
    upd_en        = bus.update_valid && !rst && !walking;
    upd_exception = (MODE == 0) ? (bus.update_pht_pred && !bus.update_taken)
                                : (!bus.update_pht_pred && bus.update_taken);
    victim_found  = 1'b0;
    victim_way    = '0;
    for (int w = Ways - 1; w >= 0; w--) begin
      if (!ent_valid[bus.update_index][w]) begin
        victim_found = 1'b1;
        victim_way   = WAY_W'(w);
      end
    end
    if (!victim_found) victim_way = rr_q[bus.update_index];
    upd_ctr_cur  = ent_ctr[bus.update_index][bus.update_way];
    upd_ctr_next = upd_ctr_cur;
    if (bus.update_taken && upd_ctr_cur != CTR_MAX)   upd_ctr_next = upd_ctr_cur + 1'b1;
    if (!bus.update_taken && upd_ctr_cur != '0)       upd_ctr_next = upd_ctr_cur - 1'b1;
  end

  // Storage has no reset of its own; the post-reset walk clears every set.
  always_ff @(posedge clk) begin
    if (walking && !rst) begin
      for (int w = 0; w < Ways; w++) ent_valid[walk_ptr_q][w] <= 1'b0;
      rr_q[walk_ptr_q] <= '0;
    end else if (upd_en) begin
      if (bus.update_hit) begin
        ent_ctr[bus.update_index][bus.update_way] <= upd_ctr_next;
      end else if (upd_exception) begin
        ent_valid[bus.update_index][victim_way] <= 1'b1;
        ent_tag[bus.update_index][victim_way]   <= bus.update_pc[Tag_size-1:0];
        ent_ctr[bus.update_index][victim_way]   <= bus.update_taken ? CTR_WEAK_T : CTR_WEAK_NT;
        if (!victim_found)
          rr_q[bus.update_index] <= (rr_q[bus.update_index] == WAY_W'(Ways - 1)) ?
                                    '0 : rr_q[bus.update_index] + 1'b1;
      end
    end
  end

  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_hit        = resp_hit_q;
  assign bus.resp_pred       = resp_pred_q;
  assign bus.resp_index      = resp_index_q;
  assign bus.resp_way        = resp_way_q;
  assign bus.flush_busy      = walking;
  assign bus.flush_state_dbg = state_q;
endmodule

// File: tb/tb_yags_direction_cache.sv
// Scoreboard bench for yags_direction_cache (MODE=0, 16 sets, 2 ways, 2-bit ctrs):
// a small reference model predicts each lookup response into exp_q.
module tb_yags_direction_cache;
  localparam int PCW = 10, GW = 10, IB = 4, WAYS = 2, TS = 8, CB = 2;
  localparam int SETS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  yags_direction_cache_if #(.PC_size(PCW), .GHR_size(GW), .Index_bits(IB), .Ways(WAYS)) bus ();

  yags_direction_cache #(
    .PC_size(PCW), .GHR_size(GW), .Index_bits(IB), .Ways(WAYS),
    .Tag_size(TS), .Ctr_bits(CB), .MODE(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [6:0] exp_q[$];
  logic [6:0] e;

  // Reference model state
  bit         m_valid[SETS][WAYS];
  logic [7:0] m_tag[SETS][WAYS];
  int         m_ctr[SETS][WAYS];
  int         m_rr[SETS];
  bit         m_walk = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  function automatic void m_find(input logic [9:0] pc, input int set, output bit hit, output int way);
    hit = 1'b0;
    way = 0;
    for (int w = 0; w < WAYS; w++)
      if (!hit && m_valid[set][w] && m_tag[set][w] == pc[7:0]) begin
        hit = 1'b1;
        way = w;
      end
  endfunction

  function automatic logic [9:0] ghr_for(input logic [9:0] pc, input int set);
    return {6'd0, pc[3:0] ^ 4'(set)};
  endfunction

  task automatic lookup_drive(input logic [9:0] pc, input logic [9:0] ghr);
    bit hit;
    int way;
    int set;
    set = int'(pc[3:0] ^ ghr[3:0]);
    m_find(pc, set, hit, way);
    if (m_walk) hit = 1'b0;
    exp_q.push_back({hit, hit && (m_ctr[set][way] >= 2), 4'(set), hit ? 1'(way) : 1'b0});
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = pc;
    bus.lookup_ghr   = ghr;
  endtask

  task automatic lookup(input logic [9:0] pc, input int set);
    lookup_drive(pc, ghr_for(pc, set));
    @(negedge clk);
    bus.lookup_valid = 1'b0;
  endtask

  task automatic update_drive(input logic [9:0] pc, input int idx, input int way,
                              input bit hit, input bit pht, input bit taken);
    int v;
    bus.update_valid    = 1'b1;
    bus.update_pc       = pc;
    bus.update_index    = 4'(idx);
    bus.update_way      = 1'(way);
    bus.update_hit      = hit;
    bus.update_pht_pred = pht;
    bus.update_taken    = taken;
    if (!m_walk) begin
      if (hit) begin
        if (taken) m_ctr[idx][way] = (m_ctr[idx][way] == 3) ? 3 : m_ctr[idx][way] + 1;
        else       m_ctr[idx][way] = (m_ctr[idx][way] == 0) ? 0 : m_ctr[idx][way] - 1;
      end else if (pht && !taken) begin
        v = -1;
        for (int w = 0; w < WAYS; w++) if (v < 0 && !m_valid[idx][w]) v = w;
        if (v < 0) begin
          v = m_rr[idx];
          m_rr[idx] = (m_rr[idx] + 1) % WAYS;
        end
        m_valid[idx][v] = 1'b1;
        m_tag[idx][v]   = pc[7:0];
        m_ctr[idx][v]   = taken ? 2 : 1;
      end
    end
  endtask

  task automatic update(input logic [9:0] pc, input int idx, input int way,
                        input bit hit, input bit pht, input bit taken);
    update_drive(pc, idx, way, hit, pht, taken);
    @(negedge clk);
    bus.update_valid = 1'b0;
  endtask

  // Counter update on whatever way the model says currently holds pc.
  task automatic hit_update(input logic [9:0] pc, input int set, input bit taken);
    bit hit;
    int way;
    m_find(pc, set, hit, way);
    update(pc, set, way, hit, 1'b1, taken);
    lookup(pc, set);
  endtask

  // Counts busy cycles, issuing a lookup each cycle and one dropped update.
  task automatic wait_walk(input int expected, input int pulse_at);
    int cnt;
    cnt = 0;
    while (bus.flush_busy && cnt < 100) begin
      cnt++;
      bus.flush_req = (cnt == pulse_at);
      if (cnt == 1) update_drive(10'h0B7, 7, 0, 1'b0, 1'b1, 1'b0);
      else bus.update_valid = 1'b0;
      lookup_drive(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
      @(negedge clk);
    end
    bus.lookup_valid = 1'b0;
    bus.update_valid = 1'b0;
    bus.flush_req    = 1'b0;
    check("walk_cycles", cnt, expected);
    check("walk_state_idle", bus.flush_state_dbg, 0);
    m_walk = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("resp_hit", bus.resp_hit, e[6]);
        check("resp_pred", bus.resp_pred, e[5]);
        check("resp_index", bus.resp_index, e[4:1]);
        check("resp_way", bus.resp_way, e[0]);
      end
    end
  end

  logic [9:0] pool[6] = '{10'h1A3, 10'h2B3, 10'h0C3, 10'h3D5, 10'h145, 10'h2F5};

  initial begin
    bus.lookup_valid = 0; bus.lookup_pc = 0; bus.lookup_ghr = 0;
    bus.update_valid = 0; bus.update_pc = 0; bus.update_index = 0; bus.update_way = 0;
    bus.update_hit = 0; bus.update_pht_pred = 0; bus.update_taken = 0; bus.flush_req = 0;
    m_clear();

    repeat (2) @(negedge clk);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_hit", bus.resp_hit, 0);
    check("rst_resp_pred", bus.resp_pred, 0);
    check("rst_resp_index", bus.resp_index, 0);
    check("rst_resp_way", bus.resp_way, 0);
    check("rst_flush_busy", bus.flush_busy, 1);
    rst = 1'b0;
    wait_walk(16, -1);
    lookup(10'h0B7, 7);

    // Allocate, then drive the counter to both saturation points
    update(10'h0A5, 3, 0, 1'b0, 1'b1, 1'b0);
    lookup_drive(10'h0A5, 10'h006);
    @(negedge clk);
    bus.lookup_valid = 1'b0;
    repeat (3) hit_update(10'h0A5, 3, 1'b1);
    repeat (3) hit_update(10'h0A5, 3, 1'b0);

    // Fill set 3 and exercise round-robin eviction
    update(10'h011, 3, 0, 1'b0, 1'b1, 1'b0);
    lookup(10'h011, 3);
    update(10'h022, 3, 0, 1'b0, 1'b1, 1'b0);
    lookup(10'h022, 3);
    lookup(10'h0A5, 3);
    update(10'h033, 3, 0, 1'b0, 1'b1, 1'b0);
    lookup(10'h033, 3);
    lookup(10'h011, 3);
    lookup(10'h022, 3);

    // Non-exception outcomes allocate nothing
    update(10'h044, 5, 0, 1'b0, 1'b0, 1'b0);
    update(10'h055, 5, 0, 1'b0, 1'b1, 1'b1);
    lookup(10'h044, 5);
    lookup(10'h055, 5);

    // Same-cycle lookup and allocate: lookup sees the old contents
    lookup_drive(10'h077, ghr_for(10'h077, 7));
    update_drive(10'h077, 7, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.lookup_valid = 1'b0;
    bus.update_valid = 1'b0;
    lookup(10'h077, 7);

    repeat (60) begin
      logic [9:0] pc;
      int set, way, op;
      bit hit;
      pc  = pool[$urandom_range(0, 5)];
      set = $urandom_range(0, 3);
      op  = $urandom_range(0, 2);
      if (op == 0) begin
        lookup(pc, set);
      end else begin
        m_find(pc, set, hit, way);
        update(pc, set, way, hit, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    @(negedge clk);

    // Flush with a second request mid-walk that must not restart it
    bus.flush_req = 1'b1;
    m_walk = 1'b1;
    m_clear();
    @(negedge clk);
    bus.flush_req = 1'b0;
    check("flush_busy_started", bus.flush_busy, 1);
    wait_walk(16, 4);
    lookup(10'h033, 3);
    lookup(10'h077, 7);
    lookup(10'h0B7, 7);

    // Refill, flush, then reset mid-walk: walk restarts from set 0
    update(10'h0A5, 3, 0, 1'b0, 1'b1, 1'b0);
    lookup(10'h0A5, 3);
    bus.flush_req = 1'b1;
    m_walk = 1'b1;
    m_clear();
    @(negedge clk);
    bus.flush_req = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_walk(16, -1);
    lookup(10'h0A5, 3);
    check("flush_busy_done", bus.flush_busy, 0);

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
